// File: rtl/tea_pkg.sv
// tea_pkg: constants shared by the TEA stream blocks and the block pad/fill helper.
package tea_pkg;
    localparam int BLOCK_BYTES = 8;
    localparam int TEA_BLOCK_W = 64;
    localparam int TEA_KEY_W = 128;
    // Lane i sits at bits [8i+7:8i] in arrival order; every lane above idx takes the pad byte.
    function automatic logic [TEA_BLOCK_W-1:0] pkcs7_fill(input logic [TEA_BLOCK_W-1:0] block,
                                                          input logic [2:0] idx, input logic mode);
        logic [7:0] pad;
        pkcs7_fill = block;
        pad = mode ? 8'(3'd7 - idx) : 8'h00;
        for (int i = 0; i < BLOCK_BYTES; i++)
            if (i > int'(idx)) pkcs7_fill[8*i +: 8] = pad;
    endfunction
endpackage

// File: rtl/tea_axis_out_reg.sv
// tea_axis_out_reg: one-entry AXI-Stream holding register; the payload is frozen while valid && !ready.
module tea_axis_out_reg #(
    parameter int W = 65
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_free,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);
    logic         r_valid;
    logic [W-1:0] r_data;
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load && o_free) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/tea_byte_packer.sv
// tea_byte_packer: packs a byte AXI-Stream message into 64-bit blocks with PKCS#7 or zero padding
// on the final block, feeding tea_accelerator through a one-entry output register.
module tea_byte_packer
    import tea_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PKCS7     = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_axis_valid_s,
    output logic                   o_axis_ready_s,
    input  logic [7:0]             i_axis_data_s,
    input  logic                   i_axis_last_s,
    output logic                   o_axis_valid_m,
    input  logic                   i_axis_ready_m,
    output logic [TEA_BLOCK_W-1:0] o_axis_data_m,
    output logic                   o_axis_last_m,
    output logic [CNT_W-1:0]       o_block_count
);
    localparam logic [TEA_BLOCK_W-1:0] PAD_BLOCK = {BLOCK_BYTES{8'h08}};

    logic [TEA_BLOCK_W-1:0] r_asm;
    logic [2:0]             r_idx;
    logic                   r_full, r_pad_pend, r_last;
    logic [CNT_W-1:0]       r_count;
    logic                   w_acc, w_close, w_free, w_load, w_pad_set, w_blk_last;
    logic [TEA_BLOCK_W-1:0] w_wr, w_fill, w_lanes, w_packed;
    logic [TEA_BLOCK_W:0]   w_out_in, w_out;

    assign o_axis_ready_s = !i_rst && !r_full && !r_pad_pend;
    assign w_acc      = i_axis_valid_s && o_axis_ready_s;
    assign w_close    = w_acc && (i_axis_last_s || r_idx == 3'd7);
    assign w_pad_set  = w_acc && i_axis_last_s && PKCS7 && r_idx == 3'd7;
    assign w_blk_last = i_axis_last_s && !(PKCS7 && r_idx == 3'd7);
    assign w_load     = r_full || r_pad_pend || w_close;

    // A closing byte bypasses asm straight into the output register when it is free.
    always_comb begin
        w_wr = r_asm;
        w_wr[8*r_idx +: 8] = i_axis_data_s;
        w_fill = i_axis_last_s ? pkcs7_fill(w_wr, r_idx, PKCS7) : w_wr;
        w_lanes = r_full ? r_asm : w_fill;
        w_packed = '0;
        for (int i = 0; i < BLOCK_BYTES; i++)
            w_packed[8*i +: 8] = MSB_FIRST ? w_lanes[8*(BLOCK_BYTES-1-i) +: 8] : w_lanes[8*i +: 8];
        w_out_in = r_full ? {r_last, w_packed} : r_pad_pend ? {1'b1, PAD_BLOCK} : {w_blk_last, w_packed};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_asm      <= '0;
            r_idx      <= '0;
            r_full     <= 1'b0;
            r_pad_pend <= 1'b0;
            r_last     <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_acc) begin
                r_asm  <= w_fill;
                r_idx  <= i_axis_last_s ? 3'd0 : r_idx + 3'd1;
                r_last <= w_blk_last;
            end
            if (w_close && !w_free) r_full <= 1'b1;
            else if (r_full && w_free) r_full <= 1'b0;
            if (w_pad_set) r_pad_pend <= 1'b1;
            else if (r_pad_pend && !r_full && w_free) r_pad_pend <= 1'b0;
            if (o_axis_valid_m && i_axis_ready_m) r_count <= r_count + CNT_W'(1);
        end
    end

    tea_axis_out_reg #(.W(TEA_BLOCK_W + 1)) u_oreg (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_data (w_out_in),
        .o_free (w_free),
        .o_valid(o_axis_valid_m),
        .o_data (w_out),
        .i_ready(i_axis_ready_m)
    );

    assign o_axis_data_m = w_out[TEA_BLOCK_W-1:0];
    assign o_axis_last_m = w_out[TEA_BLOCK_W];
    assign o_block_count = r_count;
endmodule

// File: tb/tb_tea_byte_packer.sv
// tb_tea_byte_packer: random messages checked against a chunk-and-pad reference model,
// plus directed cases pinned to hand-computed blocks.
`timescale 1ns/1ps
module tb_tea_byte_packer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        v_s = 1'b0, l_s = 1'b0, rdy_m = 1'b1, rnd_m = 1'b0;
    logic [7:0]  d_s = 8'h00;
    logic        o_rdy_s, o_v, o_l;
    logic [63:0] o_d;
    logic [15:0] o_cnt;
    logic        v1 = 1'b0, l1 = 1'b0;
    logic [7:0]  d1 = 8'h00;
    logic        r1, r2, ov1, ov2, ol1, ol2;
    logic [63:0] od1, od2;
    logic [15:0] c1, c2;

    tea_byte_packer u0 (.i_clk(clk), .i_rst(rst), .i_axis_valid_s(v_s), .o_axis_ready_s(o_rdy_s),
        .i_axis_data_s(d_s), .i_axis_last_s(l_s), .o_axis_valid_m(o_v), .i_axis_ready_m(rdy_m),
        .o_axis_data_m(o_d), .o_axis_last_m(o_l), .o_block_count(o_cnt));
    tea_byte_packer #(.MSB_FIRST(1'b1), .PKCS7(1'b0)) u1 (.i_clk(clk), .i_rst(rst), .i_axis_valid_s(v1),
        .o_axis_ready_s(r1), .i_axis_data_s(d1), .i_axis_last_s(l1), .o_axis_valid_m(ov1),
        .i_axis_ready_m(1'b1), .o_axis_data_m(od1), .o_axis_last_m(ol1), .o_block_count(c1));
    tea_byte_packer #(.MSB_FIRST(1'b0), .PKCS7(1'b0)) u2 (.i_clk(clk), .i_rst(rst), .i_axis_valid_s(v1),
        .o_axis_ready_s(r2), .i_axis_data_s(d1), .i_axis_last_s(l1), .o_axis_valid_m(ov2),
        .i_axis_ready_m(1'b1), .o_axis_data_m(od2), .o_axis_last_m(ol2), .o_block_count(c2));

    always #5 clk = ~clk;

    int          total = 0, bad = 0, n_acc = 0;
    logic [7:0]  chunk[$];
    logic [64:0] exp_q[$], got_q[$];
    logic [15:0] m_cnt = 16'd0;
    logic        stall = 1'b0;
    logic [64:0] held = '0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_got(input string nm, input int i, input logic [64:0] e);
        if (i >= got_q.size()) begin
            total++;
            bad++;
            $display("FAIL %s: no block observed, expected %h", nm, e);
        end else chk(nm, 72'(got_q[i]), 72'(e));
    endtask

    // Reference: bytes pack first-byte-most-significant; a message end pads with 8-n bytes of value 8-n.
    task automatic close_chunk(input bit last_msg);
        logic [63:0] w = '0;
        int n = chunk.size();
        for (int i = 0; i < 8; i++) w = {w[55:0], (i < n) ? chunk[i] : 8'(8 - n)};
        if (last_msg && n == 8) begin
            exp_q.push_back({1'b0, w});
            exp_q.push_back({1'b1, 64'h0808080808080808});
        end else exp_q.push_back({last_msg, w});
        chunk.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chunk.delete();
            exp_q.delete();
            m_cnt = 16'd0;
            stall = 1'b0;
        end else begin
            chk("block_count", 72'(o_cnt), 72'(m_cnt));
            if (stall) chk("stall_hold", 72'({o_v, o_l, o_d}), 72'({1'b1, held}));
            if (o_v && rdy_m) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_block: got %h expected none", {o_l, o_d});
                end else chk("block", 72'({o_l, o_d}), 72'(exp_q.pop_front()));
                got_q.push_back({o_l, o_d});
                m_cnt++;
            end
            stall = o_v && !rdy_m;
            held = {o_l, o_d};
            if (v_s && o_rdy_s) begin
                n_acc++;
                chunk.push_back(d_s);
                if (l_s) close_chunk(1'b1);
                else if (chunk.size() == 8) close_chunk(1'b0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_m) rdy_m = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [7:0] b, input bit last);
        int t = 0;
        v_s = 1'b1;
        d_s = b;
        l_s = last;
        @(negedge clk);
        while (!o_rdy_s && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!o_rdy_s) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        v_s = 1'b0;
        d_s = 8'($urandom);
        l_s = 1'($urandom);
    endtask

    task automatic send1(input logic [7:0] b, input bit last);
        v1 = 1'b1;
        d1 = b;
        l1 = last;
        @(negedge clk);
        chk("t3_ready", 72'({r1, r2}), 72'(2'b11));
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    initial begin
        int g0, a0, t;
        logic [15:0] c0;
        logic [63:0] w;
        bit done;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 72'(o_rdy_s), 72'(0));
        chk("rst_outputs", 72'({o_v, o_l, o_d}), 72'(0));
        chk("rst_count", 72'(o_cnt), 72'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 72'(o_rdy_s), 72'(1));
        @(posedge clk);
        #1;
        g0 = got_q.size();
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        repeat (4) @(negedge clk);
        chk_got("t1_data_block", g0, {1'b0, 64'h0102030405060708});
        chk_got("t1_pad_block", g0 + 1, {1'b1, 64'h0808080808080808});
        chk("t1_count", 72'(o_cnt), 72'(2));
        @(posedge clk);
        #1;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        v_s = 1'b1;
        d_s = 8'hCC;
        l_s = 1'b1;
        @(negedge clk);
        chk("t2_ready", 72'(o_rdy_s), 72'(1));
        @(posedge clk);
        #1 v_s = 1'b0;
        @(negedge clk);
        chk("t2_latency_valid", 72'(o_v), 72'(1));
        chk("t2_block", 72'({o_l, o_d}), 72'({1'b1, 64'hAABBCC0505050505}));
        @(posedge clk);
        #1;
        send1(8'hAA, 1'b0);
        send1(8'hBB, 1'b0);
        send1(8'hCC, 1'b1);
        @(negedge clk);
        chk("t3_zero_msb", 72'({ov1, ol1, od1}), 72'({2'b11, 64'hAABBCC0000000000}));
        chk("t3_zero_lsb", 72'({ov2, ol2, od2}), 72'({2'b11, 64'h0000000000CCBBAA}));
        @(negedge clk);
        chk("t3_counts", 72'({c1, c2}), 72'({16'd1, 16'd1}));
        @(posedge clk);
        #1;
        rdy_m = 1'b0;
        a0 = n_acc;
        g0 = got_q.size();
        c0 = o_cnt;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) send(8'(8'h10 + k), 1'b0);
                done = 1'b1;
            end
        join_none
        repeat (20) @(negedge clk);
        chk("t4_accepted_while_stalled", 72'(n_acc - a0), 72'(16));
        chk("t4_ready_low", 72'(o_rdy_s), 72'(0));
        @(posedge clk);
        #1 rdy_m = 1'b1;
        t = 0;
        while (!done && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("t4_sender_done", 72'(done), 72'(1));
        repeat (6) @(negedge clk);
        chk("t4_blocks", 72'(16'(o_cnt - c0)), 72'(3));
        for (int b = 0; b < 3; b++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[55:0], 8'(8'h10 + 8 * b + j)};
            chk_got("t4_block_order", g0 + b, {1'b0, w});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_in_rst", 72'(o_rdy_s), 72'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_outputs_cleared", 72'({o_v, o_l, o_d, o_cnt}), 72'(0));
        chk("t5_ready_after", 72'(o_rdy_s), 72'(1));
        @(posedge clk);
        #1;
        g0 = got_q.size();
        for (int i = 1; i <= 8; i++) send(8'(8'h30 + i), i == 8);
        repeat (4) @(negedge clk);
        chk("t5_count", 72'(o_cnt), 72'(2));
        chk_got("t5_data_block", g0, {1'b0, 64'h3132333435363738});
        chk_got("t5_pad_block", g0 + 1, {1'b1, 64'h0808080808080808});
        @(posedge clk);
        #1 rnd_m = 1'b1;
        for (int m = 0; m < 60; m++) begin
            int len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send(8'($urandom), i == len - 1);
            end
        end
        rnd_m = 1'b0;
        rdy_m = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            t++;
            @(negedge clk);
        end
        chk("drain_empty", 72'(exp_q.size()), 72'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
